// File: rtl/pc_checker.sv
// pc_checker: predicts the next PC from the driven selector, enable and ALU result, then classifies,
// counts and latches mismatches and keeps a committed-PC history. Define PC_CHK_HALT_EN to stop after the first error.
package pc_checker_pkg;
    typedef enum logic [1:0] {
        PC_4    = 2'd0,
        PC_ALU  = 2'd1,
        PC_EPC  = 2'd2,
        PC_HOLD = 2'd3
    } PCSel_e;
endpackage

module pc_checker
    import pc_checker_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ALIGN_BITS = 2,
    parameter int HIST_DEPTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [XLEN-1:0]               act_pc,
    input  PCSel_e                        drv_pc_sel,
    input  logic                          drv_pc_en,
    input  logic [XLEN-1:0]               drv_alu_res,
    input  logic                          i_clr,
    input  logic [$clog2(HIST_DEPTH)-1:0] i_hist_idx,
    output logic [XLEN-1:0]               o_exp_pc,
    output logic                          o_exp_valid,
    output logic                          o_err,
    output logic [3:0]                    o_err_code,
    output logic [XLEN-1:0]               o_err_pc,
    output logic [CNT_W-1:0]              o_err_cnt,
    output logic [CNT_W-1:0]              o_chk_cnt,
    output logic [XLEN-1:0]               o_hist_pc
);

    localparam int IDX_W = $clog2(HIST_DEPTH);

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_RUN  = 2'd1
`ifdef PC_CHK_HALT_EN
        , ST_HALT = 2'd2
`endif
    } state_e;

    state_e            state_q, state_d;

    logic [XLEN-1:0]   prev_pc_q;
    logic [XLEN-1:0]   prev_alu_q;
    PCSel_e            prev_sel_q;
    logic              prev_en_q;

    logic              err_q, err_d;
    logic [3:0]        err_code_q, err_code_d;
    logic [XLEN-1:0]   err_pc_q, err_pc_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]  chk_cnt_q, chk_cnt_d;

    logic [IDX_W-1:0]  wr_ptr_q;
    logic [XLEN-1:0]   hist_arr [HIST_DEPTH];
    logic [IDX_W-1:0]  rd_slot;

    logic              in_run;
    logic              pred_valid;
    logic [XLEN-1:0]   pred_pc;
    logic              exp_valid;
    logic              mismatch;
    logic [3:0]        code_now;
    logic              err_fire;
    logic              hist_push;

    assign in_run = (state_q == ST_RUN);

    // Prediction depends only on last cycle's registered drive, so it is stable for the whole cycle.
    always_comb begin
        pred_valid = 1'b1;
        pred_pc    = prev_pc_q;
        if (prev_en_q) begin
            case (prev_sel_q)
                PC_4:    pred_pc = prev_pc_q + XLEN'(4);
                PC_ALU:  pred_pc = prev_alu_q;
                default: begin
                    pred_valid = 1'b0;
                    pred_pc    = '0;
                end
            endcase
        end
    end

    assign exp_valid = in_run && pred_valid;
    assign mismatch  = exp_valid && (act_pc != pred_pc);

    assign code_now[0] = in_run && (|act_pc[ALIGN_BITS-1:0]);
    assign code_now[1] = mismatch && prev_en_q && (prev_sel_q == PC_4);
    assign code_now[2] = mismatch && prev_en_q && (prev_sel_q == PC_ALU);
    assign code_now[3] = mismatch && !prev_en_q;

    assign err_fire  = |code_now;
    assign hist_push = in_run && prev_en_q && !i_clr;

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        err_pc_d   = err_pc_q;
        err_cnt_d  = err_cnt_q;
        chk_cnt_d  = chk_cnt_q;
        if (i_clr) begin
            state_d    = ST_SYNC;
            err_d      = 1'b0;
            err_code_d = '0;
            err_pc_d   = '0;
            err_cnt_d  = '0;
            chk_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_SYNC: state_d = ST_RUN;
                ST_RUN: begin
                    if (err_fire && !err_q) begin
                        err_d      = 1'b1;
                        err_code_d = code_now;
                        err_pc_d   = act_pc;
                    end
                    if (err_fire && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (exp_valid && (chk_cnt_q != '1)) begin
                        chk_cnt_d = chk_cnt_q + CNT_W'(1);
                    end
`ifdef PC_CHK_HALT_EN
                    if (err_fire) begin
                        state_d = ST_HALT;
                    end
`endif
                end
`ifdef PC_CHK_HALT_EN
                ST_HALT: state_d = ST_HALT;
`endif
                default: state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_SYNC;
            err_q      <= 1'b0;
            err_code_q <= '0;
            err_pc_q   <= '0;
            err_cnt_q  <= '0;
            chk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            err_cnt_q  <= err_cnt_d;
            chk_cnt_q  <= chk_cnt_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_pc_q  <= '0;
            prev_alu_q <= '0;
            prev_sel_q <= PC_4;
            prev_en_q  <= 1'b0;
        end else if (i_clr) begin
            prev_pc_q  <= '0;
            prev_alu_q <= '0;
            prev_sel_q <= PC_4;
            prev_en_q  <= 1'b0;
        end else begin
            prev_pc_q  <= act_pc;
            prev_alu_q <= drv_alu_res;
            prev_sel_q <= drv_pc_sel;
            prev_en_q  <= drv_pc_en;
        end
    end

    // wr_ptr_q points at the slot the next push will overwrite.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
        end else if (i_clr) begin
            wr_ptr_q <= '0;
        end else if (hist_push) begin
            wr_ptr_q <= wr_ptr_q + IDX_W'(1);
        end
    end

    for (genvar gi = 0; gi < HIST_DEPTH; gi++) begin : g_hist
        logic [XLEN-1:0] ent_q;

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                ent_q <= '0;
            end else if (i_clr) begin
                ent_q <= '0;
            end else if (hist_push && (wr_ptr_q == IDX_W'(gi))) begin
                ent_q <= act_pc;
            end
        end

        assign hist_arr[gi] = ent_q;
    end

    assign rd_slot = wr_ptr_q - IDX_W'(1) - i_hist_idx;

    assign o_exp_valid = exp_valid;
    assign o_exp_pc    = exp_valid ? pred_pc : '0;
    assign o_err       = err_q;
    assign o_err_code  = err_code_q;
    assign o_err_pc    = err_pc_q;
    assign o_err_cnt   = err_cnt_q;
    assign o_chk_cnt   = chk_cnt_q;
    assign o_hist_pc   = hist_arr[rd_slot];

endmodule

// File: tb/tb_pc_checker.sv
// Directed bench for pc_checker: a cycle-level prediction model plus directed expectations feed a
// scoreboard queue that is drained and compared after each clock edge.
module tb_pc_checker;
    import pc_checker_pkg::*;

`ifdef PC_CHK_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] act_pc = '0;
    PCSel_e      drv_pc_sel = PC_4;
    logic        drv_pc_en = 1'b0;
    logic [31:0] drv_alu_res = '0;
    logic        i_clr = 1'b0;
    logic [2:0]  hidx = '0;

    logic [31:0] o_exp_pc;
    logic        o_exp_valid;
    logic        o_err;
    logic [3:0]  o_err_code;
    logic [31:0] o_err_pc;
    logic [7:0]  o_err_cnt;
    logic [7:0]  o_chk_cnt;
    logic [31:0] o_hist_pc;

    always #5 i_clk = ~i_clk;

    pc_checker #(
        .XLEN(32), .ALIGN_BITS(2), .HIST_DEPTH(8), .CNT_W(8)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .act_pc(act_pc), .drv_pc_sel(drv_pc_sel),
        .drv_pc_en(drv_pc_en), .drv_alu_res(drv_alu_res), .i_clr(i_clr),
        .i_hist_idx(hidx), .o_exp_pc(o_exp_pc), .o_exp_valid(o_exp_valid),
        .o_err(o_err), .o_err_code(o_err_code), .o_err_pc(o_err_pc),
        .o_err_cnt(o_err_cnt), .o_chk_cnt(o_chk_cnt), .o_hist_pc(o_hist_pc)
    );

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] val;
    } sb_t;

    sb_t sb_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc_n = 0;

    // Model state: 0 = SYNC, 1 = RUN, 2 = HALT.
    int          m_state = 0;
    logic [31:0] p_pc = '0;
    logic [31:0] p_alu = '0;
    logic        p_en = 1'b0;
    PCSel_e      p_sel = PC_4;

    function automatic logic [31:0] obs(input int sig);
        case (sig)
            0:       return o_exp_pc;
            1:       return {31'b0, o_exp_valid};
            2:       return {31'b0, o_err};
            3:       return {28'b0, o_err_code};
            4:       return o_err_pc;
            5:       return {24'b0, o_err_cnt};
            6:       return {24'b0, o_chk_cnt};
            default: return o_hist_pc;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sig, input logic [31:0] val);
        sb_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check_now();
        sb_t         e;
        logic [31:0] o;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs(e.sig);
            n_cmp++;
            assert (o === e.val)
            else begin
                n_bad++;
                $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic expect_zero(input string tag);
        expect_val({tag, "_exp_pc"}, 0, 32'h0);
        expect_val({tag, "_exp_valid"}, 1, 32'h0);
        expect_val({tag, "_err"}, 2, 32'h0);
        expect_val({tag, "_code"}, 3, 32'h0);
        expect_val({tag, "_err_pc"}, 4, 32'h0);
        expect_val({tag, "_err_cnt"}, 5, 32'h0);
        expect_val({tag, "_chk_cnt"}, 6, 32'h0);
        expect_val({tag, "_hist"}, 7, 32'h0);
        check_now();
    endtask

    // Starts and ends on a falling edge; the prediction for this cycle is checked before the edge.
    task automatic cycle(input logic [31:0] pc, input logic en, input PCSel_e sel,
                         input logic [31:0] alu, input logic clr);
        logic        mv;
        logic [31:0] mp;
        logic        bad;
        act_pc      = pc;
        drv_pc_en   = en;
        drv_pc_sel  = sel;
        drv_alu_res = alu;
        i_clr       = clr;
        mv = (m_state == 1) && (!p_en || p_sel == PC_4 || p_sel == PC_ALU);
        mp = !mv ? 32'h0 : (!p_en ? p_pc : (p_sel == PC_4 ? p_pc + 32'd4 : p_alu));
        expect_val("exp_valid", 1, {31'b0, mv});
        expect_val("exp_pc", 0, mp);
        check_now();
        $display("cyc %0d pc=%h en=%b sel=%s alu=%h clr=%b exp=%b/%h", cyc_n, pc, en,
                 sel.name(), alu, clr, mv, mp);
        cyc_n++;
        @(posedge i_clk);
        if (clr) begin
            m_state = 0;
            p_pc = '0; p_alu = '0; p_en = 1'b0; p_sel = PC_4;
        end else begin
            bad = (pc[1:0] != 2'b00) || (mv && (pc != mp));
            if (m_state == 0) m_state = 1;
            else if (m_state == 1 && HALT_EN && bad) m_state = 2;
            p_pc = pc; p_alu = alu; p_en = en; p_sel = sel;
        end
        @(negedge i_clk);
        i_clr = 1'b0;
    endtask

    task automatic do_clr();
        cycle(32'h0, 1'b0, PC_4, 32'h0, 1'b1);
    endtask

    // Asserts reset away from any clock edge, checks the immediate clear, releases on a falling edge.
    task automatic apply_reset(input string tag);
        #2;
        i_rst = 1'b1;
        #1;
        expect_zero(tag);
        @(negedge i_clk);
        i_rst   = 1'b0;
        m_state = 0;
        p_pc = '0; p_alu = '0; p_en = 1'b0; p_sel = PC_4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge i_clk);
        apply_reset("rst");

        // Sequential PC+4 run
        for (int i = 0; i < 5; i++) cycle(32'(i * 4), 1'b1, PC_4, 32'h0, 1'b0);
        expect_val("seq_err", 2, 32'h0);
        expect_val("seq_chk_cnt", 6, 32'd4);
        expect_val("seq_err_cnt", 5, 32'd0);
        hidx = 3'd0;
        expect_val("seq_hist0", 7, 32'h10);
        check_now();
        hidx = 3'd3;
        expect_val("seq_hist3", 7, 32'h4);
        check_now();
        hidx = 3'd4;
        expect_val("seq_hist_unwritten", 7, 32'h0);
        check_now();
        hidx = 3'd0;

        // ALU target mismatch
        cycle(32'h14, 1'b1, PC_ALU, 32'h200, 1'b0);
        cycle(32'h204, 1'b1, PC_4, 32'h0, 1'b0);
        expect_val("alu_err", 2, 32'h1);
        expect_val("alu_code", 3, 32'h4);
        expect_val("alu_err_pc", 4, 32'h204);
        expect_val("alu_err_cnt", 5, 32'd1);
        expect_val("alu_chk_cnt", 6, 32'd6);
        check_now();

`ifdef PC_CHK_HALT_EN
        for (int i = 0; i < 10; i++) cycle(32'h1000 + 32'(i * 8), 1'b0, PC_4, 32'h0, 1'b0);
        expect_val("halt_err_cnt", 5, 32'd1);
        expect_val("halt_chk_cnt", 6, 32'd6);
        expect_val("halt_code", 3, 32'h4);
        expect_val("halt_err_pc", 4, 32'h204);
        expect_val("halt_hist0", 7, 32'h204);
        check_now();
        apply_reset("halt_rst");
`endif

        // Hold mismatch, then a later misaligned PC that must not overwrite the latched code
        do_clr();
        expect_zero("clr1");
        cycle(32'h40, 1'b0, PC_4, 32'h0, 1'b0);
        cycle(32'h44, 1'b1, PC_EPC, 32'h0, 1'b0);
        expect_val("hold_code", 3, 32'h8);
        expect_val("hold_err_cnt", 5, 32'd1);
        check_now();
        cycle(32'h46, 1'b0, PC_4, 32'h0, 1'b0);
        expect_val("later_code", 3, 32'h8);
        expect_val("later_err_pc", 4, 32'h44);
        expect_val("later_err_cnt", 5, HALT_EN ? 32'd1 : 32'd2);
        expect_val("later_chk_cnt", 6, 32'd1);
        expect_val("later_hist0", 7, HALT_EN ? 32'h0 : 32'h46);
        check_now();

        // Misaligned ALU jump followed correctly
        do_clr();
        cycle(32'h100, 1'b1, PC_ALU, 32'h102, 1'b0);
        cycle(32'h102, 1'b1, PC_4, 32'h0, 1'b0);
        expect_val("misal_code", 3, 32'h1);
        expect_val("misal_err_pc", 4, 32'h102);
        expect_val("misal_err_cnt", 5, 32'd1);
        expect_val("misal_chk_cnt", 6, 32'd1);
        check_now();

        // Counter saturation
        do_clr();
        cycle(32'h0, 1'b0, PC_4, 32'h0, 1'b0);
        for (int i = 1; i <= 300; i++) cycle(32'(i * 4), 1'b0, PC_4, 32'h0, 1'b0);
        expect_val("sat_err_cnt", 5, HALT_EN ? 32'd1 : 32'd255);
        expect_val("sat_chk_cnt", 6, HALT_EN ? 32'd1 : 32'd255);
        expect_val("sat_code", 3, 32'h8);
        expect_val("sat_err_pc", 4, 32'h4);
        check_now();
        do_clr();
        expect_zero("clr_sat");

        // PC+4 wrap through 2^32 is not an error
        cycle(32'hFFFF_FFF8, 1'b1, PC_4, 32'h0, 1'b0);
        cycle(32'hFFFF_FFFC, 1'b1, PC_4, 32'h0, 1'b0);
        cycle(32'h0, 1'b1, PC_4, 32'h0, 1'b0);
        cycle(32'h4, 1'b1, PC_4, 32'h0, 1'b0);
        expect_val("wrap_err", 2, 32'h0);
        expect_val("wrap_err_cnt", 5, 32'd0);
        expect_val("wrap_chk_cnt", 6, 32'd3);
        hidx = 3'd1;
        expect_val("wrap_hist1", 7, 32'h0);
        check_now();
        hidx = 3'd2;
        expect_val("wrap_hist2", 7, 32'hFFFF_FFFC);
        check_now();
        hidx = 3'd0;

        // Combined PC+4 mismatch and misalignment, then reset mid-run
        cycle(32'h9, 1'b1, PC_4, 32'h0, 1'b0);
        expect_val("combo_code", 3, 32'h3);
        expect_val("combo_err_pc", 4, 32'h9);
        check_now();
        apply_reset("midrun_rst");
        cycle(32'h500, 1'b1, PC_4, 32'h0, 1'b0);
        cycle(32'h504, 1'b1, PC_4, 32'h0, 1'b0);
        expect_val("post_rst_err", 2, 32'h0);
        expect_val("post_rst_chk_cnt", 6, 32'd1);
        check_now();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
